// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring divide,
// with single-cycle fast paths for divide-by-zero and signed-overflow divide.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  dbg_state
);
    // Handshake: start is accepted only in IDLE or DONE; busy is high in CALC and FIX;
    // done pulses for one cycle with result valid; flush returns to IDLE without a done.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        sgn1_in, sgn2_in, neg1_in, neg2_in, fast_in;
    logic [31:0] mag1_in, mag2_in, fast_val;
    logic [32:0] mul_sum;
    logic [33:0] div_trial;
    logic [63:0] mul_next, div_next, prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_val;

    always_comb begin
        sgn1_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1_in = sgn1_in & op1[31];
        neg2_in = sgn2_in & op2[31];
        mag1_in = neg1_in ? (~op1 + 32'd1) : op1;
        mag2_in = neg2_in ? (~op2 + 32'd1) : op2;
        // Only DIV/REM (funct3[0] clear) can overflow on the most-negative dividend.
        fast_in = funct3[2] && ((op2 == 32'd0) ||
                  (!funct3[0] && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF)));
        if (op2 == 32'd0) begin
            fast_val = funct3[1] ? op1 : 32'hFFFF_FFFF;
        end else begin
            fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_trial = {1'b0, acc_q[63:31]} - {2'b00, b_q};
        div_next  = div_trial[33] ? {acc_q[62:0], 1'b0}
                                  : {div_trial[31:0], acc_q[30:0], 1'b1};
        prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (!op_q[2]) begin
            fix_val = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
        end else begin
            fix_val = op_q[1] ? rem_fix : quo_fix;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        op_d  = funct3;
                        a_d   = mag1_in;
                        b_d   = mag2_in;
                        // Multiply starts with the multiplier low; divide with the dividend low.
                        acc_d = funct3[2] ? {32'd0, mag1_in} : {32'd0, mag2_in};
                        cnt_d = 5'd0;
                        neg_d = (funct3 == 3'b110) ? neg1_in : (neg1_in ^ neg2_in);
                        if (fast_in) begin
                            result_d = fast_val;
                            state_d  = DONE;
                            done_d   = 1'b1;
                        end else begin
                            state_d = CALC;
                            busy_d  = 1'b1;
                        end
                    end
                end
                CALC: begin
                    busy_d = 1'b1;
                    acc_d  = op_q[2] ? div_next : mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = fix_val;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed RV32M cases, fast paths, control scenarios,
// and randomized operations against a plain-arithmetic reference model.
module tb_mdu;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    bit          hist_busy[0:79];
    bit          hist_done[0:79];
    logic [31:0] hist_res[0:79];

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
        .flush(flush), .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f)
            3'b000: begin p = 64'(ua * ub); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic int first_done(input int from, input int upto);
        for (int c = from; c <= upto; c++) if (hist_done[c]) return c;
        return -1;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (hist_done[c]) n++;
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (hist_busy[c]) n++;
        return n;
    endfunction

    function automatic int count_overlap(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (hist_busy[c] && hist_done[c]) n++;
        return n;
    endfunction

    // driver tasks: start is raised at a falling edge so it is sampled by the next rising edge
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
    endtask

    task automatic watch(input int ncyc, input int inj_cyc, input int inj_kind,
                         input logic [2:0] f2, input logic [31:0] a2, input logic [31:0] b2);
        for (int c = 0; c < 80; c++) begin
            hist_busy[c] = 1'b0;
            hist_done[c] = 1'b0;
            hist_res[c]  = 32'd0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            hist_busy[c] = busy;
            hist_done[c] = done;
            hist_res[c]  = result;
            if (c == 1 || c == inj_cyc + 1) begin
                start = 1'b0;
                flush = 1'b0;
            end
            if (c == inj_cyc && inj_kind == 1) begin
                start  = 1'b1;
                funct3 = f2;
                op1    = a2;
                op2    = b2;
            end
            if (c == inj_cyc && inj_kind == 2) flush = 1'b1;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_idle: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
    endtask

    task automatic test_mul_basic();
        int dc;
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        watch(36, 0, 0, 3'b000, 32'd0, 32'd0);
        dc = first_done(1, 36);
        checks++; if (dc != 34) begin errors++; $display("FAIL mul_done_cycle: got %0d want 34", dc); end
        checks++; if (hist_res[34] !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", hist_res[34]); end
        checks++; if (count_busy(1, 33) != 33 || count_busy(34, 36) != 0) begin
            errors++; $display("FAIL mul_busy_window: got %0d in 1-33 and %0d after, want 33 and 0", count_busy(1, 33), count_busy(34, 36));
        end
        checks++; if (count_done(1, 36) != 1) begin errors++; $display("FAIL mul_done_pulse: got %0d done cycles want 1", count_done(1, 36)); end
        checks++; if (count_overlap(1, 36) != 0) begin errors++; $display("FAIL mul_busy_done_overlap: got %0d want 0", count_overlap(1, 36)); end
    endtask

    task automatic test_mulh();
        logic [2:0]  fs[3] = '{3'b011, 3'b001, 3'b010};
        logic [31:0] ex[3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            launch(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            watch(35, 0, 0, 3'b000, 32'd0, 32'd0);
            checks++;
            if (first_done(1, 35) != 34 || hist_res[34] !== ex[i]) begin
                errors++; $display("FAIL mulh_f%0d: got done@%0d result %h want done@34 result %h", fs[i], first_done(1, 35), hist_res[34], ex[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] ex[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            launch(fs[i], 32'hFFFF_FFF9, 32'd2);
            watch(35, 0, 0, 3'b000, 32'd0, 32'd0);
            checks++;
            if (first_done(1, 35) != 34 || hist_res[34] !== ex[i]) begin
                errors++; $display("FAIL div_f%0d: got done@%0d result %h want done@34 result %h", fs[i], first_done(1, 35), hist_res[34], ex[i]);
            end
        end
    endtask

    task automatic test_fast();
        logic [2:0]  fs[4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            launch(fs[i], as[i], bs[i]);
            watch(4, 0, 0, 3'b000, 32'd0, 32'd0);
            checks++;
            if (!hist_done[1] || hist_res[1] !== ex[i]) begin
                errors++; $display("FAIL fast_f%0d: got done1=%b result %h want done1=1 result %h", fs[i], hist_done[1], hist_res[1], ex[i]);
            end
            checks++;
            if (count_busy(1, 4) != 0 || count_done(1, 4) != 1) begin
                errors++; $display("FAIL fast_f%0d_ctrl: got busy %0d done %0d want 0 and 1", fs[i], count_busy(1, 4), count_done(1, 4));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp_v;
        int          lat, dc;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp_q.push_back(ref_mdu(f, a, b));
            lat = is_fast(f, a, b) ? 1 : 34;
            launch(f, a, b);
            watch(36, 0, 0, 3'b000, 32'd0, 32'd0);
            dc = first_done(1, 36);
            exp_v = exp_q.pop_front();
            checks++;
            if (dc != lat || count_done(1, 36) != 1) begin
                errors++; $display("FAIL rand_latency f=%0d a=%h b=%h: got done@%0d x%0d want done@%0d x1", f, a, b, dc, count_done(1, 36), lat);
            end
            checks++;
            if (hist_res[lat] !== exp_v) begin
                errors++; $display("FAIL rand_result f=%0d a=%h b=%h: got %h want %h", f, a, b, hist_res[lat], exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp_v;
        exp_v = ref_mdu(3'b100, 32'hFFFF_FF9C, 32'd7);
        launch(3'b100, 32'hFFFF_FF9C, 32'd7);
        watch(37, 5, 1, 3'b000, 32'd9, 32'd9);
        checks++;
        if (first_done(1, 37) != 34 || count_done(1, 37) != 1 || hist_res[34] !== exp_v) begin
            errors++; $display("FAIL ignore_start: got done@%0d x%0d result %h want done@34 x1 result %h", first_done(1, 37), count_done(1, 37), hist_res[34], exp_v);
        end
        checks++;
        if (count_busy(1, 33) != 33) begin errors++; $display("FAIL ignore_start_busy: got %0d want 33", count_busy(1, 33)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        e1 = ref_mdu(3'b101, 32'h1234_5678, 32'h0000_0123);
        e2 = ref_mdu(3'b110, 32'hFFFF_F000, 32'h0000_0007);
        launch(3'b101, 32'h1234_5678, 32'h0000_0123);
        watch(70, 34, 1, 3'b110, 32'hFFFF_F000, 32'h0000_0007);
        checks++;
        if (first_done(1, 70) != 34 || hist_res[34] !== e1) begin
            errors++; $display("FAIL b2b_first: got done@%0d result %h want done@34 result %h", first_done(1, 70), hist_res[34], e1);
        end
        checks++; if (!hist_busy[35]) begin errors++; $display("FAIL b2b_busy35: got 0 want 1"); end
        checks++;
        if (first_done(35, 70) != 68 || hist_res[68] !== e2) begin
            errors++; $display("FAIL b2b_second: got done@%0d result %h want done@68 result %h", first_done(35, 70), hist_res[68], e2);
        end
        checks++; if (count_done(1, 70) != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", count_done(1, 70)); end
        checks++; if (count_overlap(1, 70) != 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", count_overlap(1, 70)); end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        launch(3'b101, 32'hDEAD_BEEF, 32'd3);
        prev = result;
        watch(40, 10, 2, 3'b000, 32'd0, 32'd0);
        checks++;
        if (!hist_busy[10] || hist_busy[11]) begin
            errors++; $display("FAIL flush_busy: got busy10=%b busy11=%b want 1 and 0", hist_busy[10], hist_busy[11]);
        end
        checks++; if (count_done(1, 40) != 0) begin errors++; $display("FAIL flush_no_done: got %0d want 0", count_done(1, 40)); end
        checks++; if (hist_res[40] !== prev) begin errors++; $display("FAIL flush_result: got %h want %h", hist_res[40], prev); end
    endtask

    task automatic test_async_reset();
        launch(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
        watch(10, 0, 0, 3'b000, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        watch(6, 0, 0, 3'b000, 32'd0, 32'd0);
        checks++;
        if (count_done(1, 6) != 0 || count_busy(1, 6) != 0) begin
            errors++; $display("FAIL async_reset_quiet: got done %0d busy %0d want 0 and 0", count_done(1, 6), count_busy(1, 6));
        end
        launch(3'b000, 32'd3, 32'd4);
        watch(36, 0, 0, 3'b000, 32'd0, 32'd0);
        checks++;
        if (first_done(1, 36) != 34 || hist_res[34] !== 32'd12) begin
            errors++; $display("FAIL async_reset_mul: got done@%0d result %h want done@34 result 0000000c", first_done(1, 36), hist_res[34]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op1    = 32'd0;
        op2    = 32'd0;
        test_reset();
        test_mul_basic();
        test_mulh();
        test_div();
        test_fast();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle integer ALU. The ALU covers the base-ISA single-cycle ops; the mdu takes the same operand pair (op1/op2) with the M-extension funct3 and returns the result after a multi-cycle shift-add or restoring-divide sequence. Handshake is start/busy/done. The pipeline stalls on busy and captures result on done.

## Interface
- No parameters; datapath fixed at 32 bits.

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  in  32  rs1 value (multiplicand / dividend); sampled with start
- op2  in  32  rs2 value (multiplier / divisor); sampled with start
- flush  in  1  pipeline kill; aborts any operation in progress
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; result valid this cycle
- result  out  32  registered result; holds its value until the next done

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start:
  - Latch funct3 and operand magnitudes.
  - Latch the result-sign flags.
  - Clear the 5-bit counter.
  - Go to CALC.
  - Fast path: go directly to DONE, loading result.
- Fast paths (divide ops only):
  - divisor == 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = op1.
  - DIV/REM with op1 = 0x80000000 and op2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - All others: unsigned.
  - Signed operands are converted to magnitude (two's complement negate if bit31 set).
- CALC: one iteration per cycle, counter 0..31; at count 31 go to FIX.
  - Multiply: 64-bit shift-add over the 32 multiplier bits; full 64-bit unsigned magnitude product.
  - Divide: restoring division; 64-bit {remainder, quotient} shift register; trial subtract of the 33-bit divisor magnitude each cycle.
- FIX: apply sign, select output, load result, go to DONE.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend sign.
  - MUL → low 32 bits; MULH/MULHSU/MULHU → high 32 bits.
- DONE: done = 1 for exactly one cycle.
  - Next state is IDLE, or CALC (or DONE for a fast path) if start is high. Back-to-back issue is allowed.
- start during CALC/FIX: ignored, no effect on the operation.
- flush: next state IDLE from any state.
  - No done is produced; result is unchanged.
  - flush has priority over start in the same cycle.
- All arithmetic is modulo 2^32 on outputs. Internal accumulators are 64 bits, plus a 33-bit subtract for divide.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, busy 0, done 0, result 0x00000000, counter 0, internal registers 0.
- Reset asserted mid-operation aborts immediately. No done follows deassertion.
- Normal latency: start high in cycle 0 → busy high cycles 1-33 (CALC 1-32, FIX 33) → done high in cycle 34, with result valid in the same cycle.
- Fast-path latency: start in cycle 0 → done in cycle 1; busy never asserts.
- done and busy are never high together.
- result changes only on the edge that enters DONE.
- flush in cycle k → state IDLE and busy low from cycle k+1.
- Back-to-back: start in a done cycle (cycle 34) → busy in cycle 35 → next done in cycle 68.

## Test plan
- MUL: op1 = 7, op2 = 0xFFFFFFFD, start in cycle 0 → done in cycle 34, result 0xFFFFFFEB; busy high cycles 1-33 only.
- High-half multiply, op1 = op2 = 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Signed divide, op1 = 0xFFFFFFF9 (-7), op2 = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Fast paths, each with done in cycle 1 and busy never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Control: start a DIV, re-pulse start in cycle 5 with different operands (ignored; original result appears in cycle 34), and start the next op in cycle 34 (next done in cycle 68). Separately, flush in cycle 10 → busy low in cycle 11, no done, result unchanged.
- Async reset: drop rst_n mid-CALC (between clock edges) → busy, done, and result go to 0 immediately; after release, no spurious done, and a new MUL 3×4 returns 12 after 34 cycles.
